// File: rtl/lsu_pkg.sv
// lsu_pkg: shared Func3 encodings and FSM state type for the memory-stage LSU
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane replication/strobes and load byte select with extension
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_f3_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_wstrb_o,
  input  logic [2:0]  ld_f3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  always_comb begin
    st_wdata_o = st_f3_i == F3_B ? {4{st_data_i[7:0]}} :
                 st_f3_i == F3_H ? {2{st_data_i[15:0]}} : st_data_i;
    st_wstrb_o = st_f3_i == F3_B ? 4'b0001 << st_off_i :
                 st_f3_i == F3_H ? (st_off_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    ld_b = ld_rdata_i[{ld_off_i, 3'b000} +: 8];
    ld_h = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    ld_data_o = ld_f3_i == F3_B  ? {{24{ld_b[7]}}, ld_b} :
                ld_f3_i == F3_BU ? {24'b0, ld_b} :
                ld_f3_i == F3_H  ? {{16{ld_h[15]}}, ld_h} :
                ld_f3_i == F3_HU ? {16'b0, ld_h} : ld_rdata_i;
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: M-stage load/store unit driving a single-outstanding req/ack data bus
module mem_stage_lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  Func3M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] ReadDataM,
  output logic        LsuStallM,
  output logic        ErrM
);
  state_e      state_q;
  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_wstrb;
  logic        access, f3_ok, aligned, legal;
  lsu_align u_align (
    .st_f3_i   (Func3M),
    .st_off_i  (ALUResultM[1:0]),
    .st_data_i (WriteDataM),
    .st_wdata_o(st_wdata),
    .st_wstrb_o(st_wstrb),
    .ld_f3_i   (f3_q),
    .ld_off_i  (off_q),
    .ld_rdata_i(dmem_rdata),
    .ld_data_o (ld_data)
  );
  // Func3 bit1 marks word, bit0 marks half; unsupported codes are rejected by f3_ok
  always_comb begin
    access    = MemReadM ^ MemWriteM;
    f3_ok     = Func3M inside {F3_B, F3_H, F3_W} || (MemReadM && Func3M inside {F3_BU, F3_HU});
    aligned   = Func3M[1] ? ALUResultM[1:0] == 2'b00 : Func3M[0] ? !ALUResultM[0] : 1'b1;
    legal     = access && f3_ok && aligned;
    ErrM      = state_q == IDLE && (MemReadM || MemWriteM) && !legal;
    LsuStallM = state_q == BUSY || (state_q == IDLE && legal);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (legal) begin
          state_q <= BUSY;
          req_q   <= 1'b1;
          we_q    <= MemWriteM;
          addr_q  <= {ALUResultM[31:2], 2'b00};
          wdata_q <= MemWriteM ? st_wdata : '0;
          wstrb_q <= MemWriteM ? st_wstrb : 4'b0000;
          f3_q    <= Func3M;
          off_q   <= ALUResultM[1:0];
        end
        BUSY: if (dmem_ack) begin
          state_q <= DONE;
          req_q   <= 1'b0;
          if (!we_q) rdata_q <= ld_data;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_wstrb = wstrb_q;
  assign ReadDataM  = rdata_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: randomized scoreboard bench for mem_stage_lsu
module tb_mem_stage_lsu;
  logic        clk = 1'b0, reset = 1'b1;
  logic        MemReadM = 1'b0, MemWriteM = 1'b0, dmem_ack = 1'b0;
  logic [31:0] ALUResultM = '0, WriteDataM = '0, dmem_rdata = '0;
  logic [2:0]  Func3M = '0;
  logic        dmem_req, dmem_we, LsuStallM, ErrM;
  logic [31:0] dmem_addr, dmem_wdata, ReadDataM;
  logic [3:0]  dmem_wstrb;

  mem_stage_lsu dut (
    .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .Func3M(Func3M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .ReadDataM(ReadDataM), .LsuStallM(LsuStallM), .ErrM(ErrM)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] res;
    int          stalls;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int size_of(logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit legal_m(bit rd, bit wr, logic [2:0] f3, logic [31:0] a);
    int s = size_of(f3);
    if (rd == wr || s == 0 || (wr && f3 > 3'd3)) return 1'b0;
    return int'(a % 4) % s == 0;
  endfunction

  task automatic clear_inputs();
    MemReadM = 1'b0; MemWriteM = 1'b0;
    ALUResultM = $urandom; WriteDataM = $urandom; Func3M = 3'($urandom_range(0, 7));
  endtask

  // Issues one M-stage access and plays the memory side; dly = extra BUSY cycles before ack
  task automatic do_access(bit rd, bit wr, logic [31:0] a, logic [31:0] wd,
                           logic [2:0] f3, logic [31:0] rword, int dly);
    exp_t e;
    int   s = size_of(f3);
    int   off = int'(a % 4);
    logic [31:0] v, mask;
    MemReadM = rd; MemWriteM = wr; ALUResultM = a; WriteDataM = wd; Func3M = f3;
    e.err = !legal_m(rd, wr, f3, a);
    if (e.err) begin
      q.push_back(e);
      @(posedge clk); #1;
      clear_inputs();
      return;
    end
    e.we = wr;
    e.addr = a - 32'(off);
    e.wdata = '0;
    e.wstrb = '0;
    for (int i = 0; i < 4; i++) begin
      e.wdata[8*i +: 8] = wd[8*(i % s) +: 8];
      e.wstrb[i] = wr && i >= off && i < off + s;
    end
    if (!wr) e.wdata = '0;
    mask = s == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * s)) - 1;
    v = (rword >> (8 * off)) & mask;
    if (s < 4 && f3 < 3'd4 && v[8*s-1]) v = v | ~mask;
    e.res = v;
    e.stalls = 2 + dly;
    q.push_back(e);
    @(posedge clk); #1;
    repeat (dly) begin @(posedge clk); #1; end
    dmem_ack = 1'b1; dmem_rdata = rword;
    @(posedge clk); #1;
    dmem_ack = 1'b0; dmem_rdata = $urandom;
    clear_inputs();
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
  endtask

  // Reset lands while a load waits in BUSY; a late ack must not revive it
  task automatic reset_in_busy();
    exp_t e;
    MemReadM = 1'b1; MemWriteM = 1'b0; ALUResultM = 32'h0000_0040; Func3M = 3'd2;
    e.err = 1'b0; e.we = 1'b0; e.addr = 32'h40; e.wdata = '0; e.wstrb = '0; e.res = '0; e.stalls = 0;
    q.push_back(e);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    reset = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  exp_t cur;
  bit   active = 1'b0, prev_req = 1'b0, reset_seen = 1'b0;
  int   stall_cnt = 0;
  logic [31:0] exp_rd = '0;

  always @(negedge clk) begin
    if (reset) begin
      active = 1'b0; exp_rd = '0; stall_cnt = 0; prev_req = 1'b0; reset_seen = 1'b1;
    end else begin
      if (reset_seen) begin
        reset_seen = 1'b0;
        check("rst_we", 32'(dmem_we), 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_wstrb", 32'(dmem_wstrb), 32'd0);
        check("rst_rdata", ReadDataM, 32'd0);
      end
      if (LsuStallM) stall_cnt++;
      if (ErrM) begin
        if (q.size() == 0) check("err_unexpected", 32'd1, 32'd0);
        else begin
          cur = q.pop_front();
          check("err_flag", 32'(cur.err), 32'd1);
        end
        check("err_req", 32'(dmem_req), 32'd0);
        check("err_stall", 32'(LsuStallM), 32'd0);
      end
      if (dmem_req && !prev_req) begin
        if (q.size() == 0) check("req_unexpected", 32'd1, 32'd0);
        else begin
          cur = q.pop_front();
          check("req_legal", 32'(cur.err), 32'd0);
          active = 1'b1;
        end
      end
      if (active && dmem_req) begin
        check("busy_stall", 32'(LsuStallM), 32'd1);
        check("bus_we", 32'(dmem_we), 32'(cur.we));
        check("bus_addr", dmem_addr, cur.addr);
        check("bus_wstrb", 32'(dmem_wstrb), 32'(cur.wstrb));
        if (cur.we) check("bus_wdata", dmem_wdata, cur.wdata);
      end
      if (active && !dmem_req && prev_req) begin
        active = 1'b0;
        check("done_stall", 32'(LsuStallM), 32'd0);
        check("stall_cycles", 32'(stall_cnt), 32'(cur.stalls));
        stall_cnt = 0;
        if (!cur.we) exp_rd = cur.res;
        check("ReadDataM", ReadDataM, exp_rd);
      end
      if (!active && !MemReadM && !MemWriteM) begin
        check("idle_req", 32'(dmem_req), 32'd0);
        check("idle_stall", 32'(LsuStallM), 32'd0);
        check("idle_err", 32'(ErrM), 32'd0);
        check("idle_rdata", ReadDataM, exp_rd);
      end
      prev_req = dmem_req;
    end
  end

  initial begin
    bit          rd, wr;
    logic [31:0] a;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(2);
    do_access(1'b0, 1'b1, 32'h0000_1003, 32'hAABB_CCDD, 3'd0, 32'h0, 0);
    do_access(1'b1, 1'b0, 32'h0000_2001, 32'h0, 3'd4, 32'h1234_8056, 0);
    do_access(1'b1, 1'b0, 32'h0000_2001, 32'h0, 3'd0, 32'h1234_8056, 0);
    do_access(1'b1, 1'b0, 32'h0000_2004, 32'h0, 3'd2, 32'hCAFE_F00D, 3);
    do_access(1'b1, 1'b0, 32'h0000_3001, 32'h0, 3'd1, 32'h0, 0);
    do_access(1'b0, 1'b1, 32'h0000_3002, 32'h1111_2222, 3'd2, 32'h0, 0);
    do_access(1'b1, 1'b0, 32'h0000_3000, 32'h0, 3'd3, 32'h0, 0);
    do_access(1'b1, 1'b1, 32'h0000_3000, 32'h0, 3'd0, 32'h0, 0);
    do_access(1'b0, 1'b1, 32'h0000_4002, 32'h1357_9BDF, 3'd1, 32'h0, 1);
    do_access(1'b1, 1'b0, 32'h0000_4002, 32'h0, 3'd5, 32'h9ABC_1234, 2);
    do_access(1'b1, 1'b0, 32'h0000_4002, 32'h0, 3'd1, 32'h9ABC_1234, 0);
    do_access(1'b0, 1'b1, 32'h0000_4001, 32'h0, 3'd4, 32'h0, 0);
    idle(3);
    reset_in_busy();
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0, 2:    begin rd = 1'b1; wr = 1'b0; end
        1:       begin rd = 1'b0; wr = 1'b1; end
        default: begin rd = 1'b1; wr = 1'b1; end
      endcase
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      do_access(rd, wr, a, $urandom, 3'($urandom_range(0, 7)), $urandom, int'($urandom_range(0, 4)));
      idle(int'($urandom_range(0, 2)));
    end
    idle(3);
    check("queue_empty", 32'(q.size()), 32'd0);
    check("no_active", 32'(active), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit of the RV32I pipeline. It consumes the M-stage data and control signals produced by the E/M pipeline register, drives a single-outstanding request/acknowledge data-memory bus, and returns a sign- or zero-extended load result toward the M/W register. While an access is in flight it stalls the pipeline. It flags misaligned or illegal accesses instead of issuing them.

## Interface
Parameters:
- none; address and data width fixed at 32.

Ports:
- clk  in  1  single clock, all state on posedge.
- reset  in  1  synchronous, active-high reset.
- MemReadM  in  1  load in M stage.
- MemWriteM  in  1  store in M stage.
- ALUResultM  in  32  effective byte address.
- WriteDataM  in  32  store data (rs2).
- Func3M  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- dmem_req  out  1  request valid, registered.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word address {addr[31:2],2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_wstrb  out  4  byte enables (0000 on reads).
- dmem_rdata  in  32  read word, valid with ack.
- dmem_ack  in  1  completes the current request.
- ReadDataM  out  32  extended load result, registered.
- LsuStallM  out  1  freeze F/D/E/M stages.
- ErrM  out  1  misaligned/illegal access this cycle.

## Operation
- FSM states: IDLE, BUSY, DONE.
- Access is MemReadM xor MemWriteM. Legal means Func3 is supported (stores: 000/001/010 only) and aligned (H: addr[0]=0; W: addr[1:0]=0).
- IDLE, legal access: latch addr/we/wdata/wstrb/Func3, set dmem_req, go BUSY; LsuStallM=1 combinationally.
- IDLE, illegal access: ErrM=1, no request, no stall, ReadDataM unchanged, stay IDLE. Illegal covers both MemRead and MemWrite asserted, unsupported Func3, or misalignment.
- BUSY: hold dmem_req and all bus outputs stable, LsuStallM=1. On dmem_ack: clear dmem_req. For a read, load ReadDataM from the formatted dmem_rdata. Go DONE.
- DONE: LsuStallM=0, so the instruction leaves M at this edge. The M-stage inputs are ignored. Next state IDLE.
- Store format:
  - B: wdata={4{wd[7:0]}}, wstrb=0001<<addr[1:0].
  - H: wdata={2{wd[15:0]}}, wstrb=addr[1]?1100:0011.
  - W: wdata=wd, wstrb=1111.
- Load format: select byte/half at the latched addr[1:0]. B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
- dmem_ack in IDLE or DONE is ignored.

## Timing
- Reset values: state IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_wstrb=0, ReadDataM=0. LsuStallM=0 and ErrM=0 follow from IDLE with no access.
- Minimum latency is 3 cycles: C0 IDLE (stall), C1 BUSY with req (ack earliest here), C2 DONE (result valid, no stall).
- Each ack wait cycle in BUSY adds one stall cycle; there is no timeout.
- Exactly one outstanding request at a time; no back-to-back issue. After DONE comes at least one IDLE cycle before the next req.
- Reset asserted in BUSY: next cycle IDLE with req=0. A late ack is ignored and ReadDataM=0.
- ReadDataM holds its value until the next completed load or reset. Stores never modify it.

## Structure
- Package lsu_pkg holds the Func3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
- One combinational sub-module, lsu_align, holds the store lane replication, strobe generation, load byte select and extension. The top level contains the FSM and registers.

## Test plan
- SB, addr 0x1003, WriteDataM 0xAABBCCDD, ack on the first BUSY cycle: wstrb 1000, wdata 0xDDDDDDDD, dmem_addr 0x1000, stall for 2 cycles.
- LB, addr 0x2001, rdata 0x12348056: ReadDataM 0x00000080 for LBU and 0xFFFFFF80 for LB, valid in DONE.
- LW with ack delayed 4 cycles: req and bus outputs stable throughout, 5 stall cycles, ReadDataM equals rdata.
- LH at addr 0x3001 and SW at addr 0x3002: ErrM=1 for one cycle, dmem_req never rises, no stall.
- Reset pulsed in BUSY, then ack arrives: FSM returns to IDLE, req=0, ReadDataM=0, and the ack has no effect.
- Func3 011 load, and MemReadM and MemWriteM both asserted: ErrM=1 and no request.
